// File: rtl/mem_access.sv
// mem_access: load/store memory stage with a req/ack data-memory port, byte-lane steering and load extension.
// Build option MEM_TIMEOUT_EN completes an unacknowledged access as an error after TIMEOUT_CYCLES.
module mem_access #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [5:0]  alucode,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  localparam logic [5:0] ALU_LB  = 6'd16;
  localparam logic [5:0] ALU_LH  = 6'd17;
  localparam logic [5:0] ALU_LW  = 6'd18;
  localparam logic [5:0] ALU_LBU = 6'd19;
  localparam logic [5:0] ALU_LHU = 6'd20;
  localparam logic [5:0] ALU_SB  = 6'd21;
  localparam logic [5:0] ALU_SH  = 6'd22;
  localparam logic [5:0] ALU_SW  = 6'd23;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_cfg
    $error("mem_access: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  state_t      state_r;
  state_t      next_state_s;
  logic [1:0]  size_s;
  logic        sgn_s;
  logic        code_load_s;
  logic        code_store_s;
  logic        code_ok_s;
  logic        align_ok_s;
  logic        legal_s;
  logic        accept_s;
  logic        timeout_s;
  logic [1:0]  size_r;
  logic [1:0]  lane_r;
  logic        sgn_r;
  logic        load_r;
  logic        busy_s;
  logic        done_s;
  logic        misaligned_s;
  logic        dmem_req_s;
  logic        dmem_we_s;
  logic [31:0] load_data_s;
  logic [31:0] dmem_addr_s;
  logic [31:0] dmem_wdata_s;
  logic [3:0]  dmem_wstrb_s;

  function automatic logic [3:0] steer_strb(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] strb;
    case (size)
      SZ_B:    strb = 4'b0001 << lane;
      SZ_H:    strb = lane[1] ? 4'b1100 : 4'b0011;
      SZ_W:    strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] steer_data(input logic [1:0] size, input logic [31:0] data);
    logic [31:0] wd;
    case (size)
      SZ_B:    wd = {4{data[7:0]}};
      SZ_H:    wd = {2{data[15:0]}};
      SZ_W:    wd = data;
      default: wd = 32'h0000_0000;
    endcase
    return wd;
  endfunction

  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic sgn,
                                              input logic [1:0] lane, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_B:    r = sgn ? {{24{b[7]}}, b} : {24'h00_0000, b};
      SZ_H:    r = sgn ? {{16{h[15]}}, h} : {16'h0000, h};
      SZ_W:    r = rdata;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  // Decode access kind and check alignment of the incoming request
  always_comb begin
    size_s       = SZ_B;
    sgn_s        = 1'b0;
    code_load_s  = 1'b0;
    code_store_s = 1'b0;
    code_ok_s    = 1'b1;
    case (alucode)
      ALU_LB:  begin sgn_s = 1'b1; code_load_s = 1'b1; end
      ALU_LH:  begin size_s = SZ_H; sgn_s = 1'b1; code_load_s = 1'b1; end
      ALU_LW:  begin size_s = SZ_W; code_load_s = 1'b1; end
      ALU_LBU: begin code_load_s = 1'b1; end
      ALU_LHU: begin size_s = SZ_H; code_load_s = 1'b1; end
      ALU_SB:  begin code_store_s = 1'b1; end
      ALU_SH:  begin size_s = SZ_H; code_store_s = 1'b1; end
      ALU_SW:  begin size_s = SZ_W; code_store_s = 1'b1; end
      default: begin code_ok_s = 1'b0; end
    endcase
    case (size_s)
      SZ_B:    align_ok_s = 1'b1;
      SZ_H:    align_ok_s = ~addr[0];
      SZ_W:    align_ok_s = (addr[1:0] == 2'b00);
      default: align_ok_s = 1'b0;
    endcase
  end

  // A kind that disagrees with the load/store flags is rejected like a misalignment
  assign accept_s = start & (is_load | is_store);
  assign legal_s  = code_ok_s & (is_load ^ is_store) &
                    (is_load ? code_load_s : code_store_s) & align_ok_s;

`ifdef MEM_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_r;

  assign timeout_s = (state_r == ACCESS) && !dmem_ack &&
                     (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count ACCESS cycles spent waiting for the acknowledge
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (state_r == IDLE && accept_s && legal_s) begin
      cnt_r <= '0;
    end else if (state_r == ACCESS && !dmem_ack) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= cnt_r;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && legal_s) begin
          next_state_s = ACCESS;
        end else if (accept_s) begin
          next_state_s = RESP;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS: begin
        if (dmem_ack || timeout_s) begin
          next_state_s = RESP;
        end else begin
          next_state_s = ACCESS;
        end
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs; port fields are held while ACCESS waits
  always_comb begin
    busy_s       = (next_state_s != IDLE);
    done_s       = (next_state_s == RESP);
    dmem_req_s   = (next_state_s == ACCESS);
    misaligned_s = 1'b0;
    load_data_s  = load_data;
    dmem_addr_s  = dmem_addr;
    dmem_wdata_s = dmem_wdata;
    dmem_we_s    = 1'b0;
    dmem_wstrb_s = 4'b0000;
    case (state_r)
      IDLE: begin
        if (next_state_s == ACCESS) begin
          dmem_addr_s  = {addr[31:2], 2'b00};
          dmem_we_s    = is_store;
          dmem_wstrb_s = is_store ? steer_strb(size_s, addr[1:0]) : 4'b0000;
          dmem_wdata_s = is_store ? steer_data(size_s, store_data) : 32'h0000_0000;
        end else if (next_state_s == RESP) begin
          misaligned_s = 1'b1;
          load_data_s  = 32'h0000_0000;
        end else begin
          load_data_s  = load_data;
        end
      end
      ACCESS: begin
        if (next_state_s == RESP) begin
          misaligned_s = timeout_s;
          load_data_s  = (dmem_ack && load_r) ? load_extend(size_r, sgn_r, lane_r, dmem_rdata)
                                              : 32'h0000_0000;
        end else begin
          dmem_we_s    = dmem_we;
          dmem_wstrb_s = dmem_wstrb;
        end
      end
      RESP:    load_data_s = load_data;
      default: load_data_s = load_data;
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      load_data  <= 32'h0000_0000;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0000_0000;
      dmem_wdata <= 32'h0000_0000;
      dmem_wstrb <= 4'b0000;
    end else begin
      busy       <= busy_s;
      done       <= done_s;
      misaligned <= misaligned_s;
      load_data  <= load_data_s;
      dmem_req   <= dmem_req_s;
      dmem_we    <= dmem_we_s;
      dmem_addr  <= dmem_addr_s;
      dmem_wdata <= dmem_wdata_s;
      dmem_wstrb <= dmem_wstrb_s;
    end
  end

  // Request attributes needed later to extract the load result
  always_ff @(posedge clk) begin
    if (rst) begin
      size_r <= SZ_B;
      lane_r <= 2'b00;
      sgn_r  <= 1'b0;
      load_r <= 1'b0;
    end else if (state_r == IDLE && accept_s && legal_s) begin
      size_r <= size_s;
      lane_r <= addr[1:0];
      sgn_r  <= sgn_s;
      load_r <= is_load;
    end else begin
      size_r <= size_r;
      lane_r <= lane_r;
      sgn_r  <= sgn_r;
      load_r <= load_r;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for mem_access (stores, loads, errors, reset abort, optional timeout).
module tb_mem_access;

  localparam logic [5:0] ALU_LB  = 6'd16;
  localparam logic [5:0] ALU_LH  = 6'd17;
  localparam logic [5:0] ALU_LW  = 6'd18;
  localparam logic [5:0] ALU_LBU = 6'd19;
  localparam logic [5:0] ALU_LHU = 6'd20;
  localparam logic [5:0] ALU_SB  = 6'd21;
  localparam logic [5:0] ALU_SH  = 6'd22;
  localparam logic [5:0] ALU_SW  = 6'd23;

`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [5:0]  alucode = 6'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        busy, done, misaligned, dmem_req, dmem_we;
  logic [31:0] load_data, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'hBAD0_BAD0;

  int n_checks = 0;
  int n_fail   = 0;

  // Captures filled by run_access
  logic        r_req, r_we, r_held, r_busy_all, r_done_early;
  logic [31:0] r_addr, r_wdata, r_ld;
  logic [3:0]  r_wstrb;
  logic        r_done, r_mis, r_req_done, r_done_after, r_busy_after, r_mis_after;

  mem_access #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
    .alucode(alucode), .addr(addr), .store_data(store_data), .busy(busy), .done(done),
    .load_data(load_data), .misaligned(misaligned), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one access; ack after ack_wait request cycles (ignored when no request appears)
  task automatic run_access(input logic ld, input logic st, input logic [5:0] code,
                            input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rd, input int ack_wait);
    start = 1'b1; is_load = ld; is_store = st; alucode = code; addr = a; store_data = sd;
    tick();
    start = 1'b0; is_load = 1'b0; is_store = 1'b0; alucode = 6'd0;
    addr = 32'hFFFF_FFFF; store_data = 32'h5555_AAAA;
    r_req = dmem_req; r_addr = dmem_addr; r_we = dmem_we; r_wstrb = dmem_wstrb;
    r_wdata = dmem_wdata; r_held = 1'b1; r_busy_all = busy; r_done_early = done & dmem_req;
    if (dmem_req === 1'b1) begin
      for (int i = 0; i < ack_wait; i++) begin
        tick();
        if (dmem_req !== 1'b1 || dmem_addr !== r_addr || dmem_we !== r_we ||
            dmem_wstrb !== r_wstrb || dmem_wdata !== r_wdata) r_held = 1'b0;
        if (busy !== 1'b1) r_busy_all = 1'b0;
        if (done !== 1'b0) r_done_early = 1'b1;
      end
      dmem_ack = 1'b1; dmem_rdata = rd;
      tick();
      dmem_ack = 1'b0; dmem_rdata = 32'hBAD0_BAD0;
      if (busy !== 1'b1) r_busy_all = 1'b0;
    end
    r_done = done; r_mis = misaligned; r_ld = load_data; r_req_done = dmem_req;
    tick();
    r_done_after = done; r_busy_after = busy; r_mis_after = misaligned;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; is_load = 1'b1; alucode = ALU_LW; addr = 32'h40;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0b want 0", busy); end
    n_checks++; if (done !== 1'b0 || misaligned !== 1'b0) begin n_fail++; $display("FAIL rst_done_mis got %0b%0b want 00", done, misaligned); end
    n_checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin n_fail++; $display("FAIL rst_req_we got %0b%0b want 00", dmem_req, dmem_we); end
    n_checks++; if (load_data !== 32'h0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_data got %h %h %h want zeros", load_data, dmem_addr, dmem_wdata); end
    n_checks++; if (dmem_wstrb !== 4'b0000) begin n_fail++; $display("FAIL rst_wstrb got %b want 0000", dmem_wstrb); end
    start = 1'b0; is_load = 1'b0; rst = 1'b0;
    tick();
  endtask

  task automatic test_store_word();
    run_access(1'b0, 1'b1, ALU_SW, 32'h100, 32'hDEADBEEF, 32'h0, 2);
    n_checks++; if (r_req !== 1'b1) begin n_fail++; $display("FAIL sw_req got %0b want 1", r_req); end
    n_checks++; if (r_addr !== 32'h100) begin n_fail++; $display("FAIL sw_addr got %h want 00000100", r_addr); end
    n_checks++; if (r_we !== 1'b1) begin n_fail++; $display("FAIL sw_we got %0b want 1", r_we); end
    n_checks++; if (r_wstrb !== 4'b1111) begin n_fail++; $display("FAIL sw_wstrb got %b want 1111", r_wstrb); end
    n_checks++; if (r_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_wdata got %h want deadbeef", r_wdata); end
    n_checks++; if (r_held !== 1'b1) begin n_fail++; $display("FAIL sw_held got %0b want 1", r_held); end
    n_checks++; if (r_busy_all !== 1'b1) begin n_fail++; $display("FAIL sw_busy got %0b want 1", r_busy_all); end
    n_checks++; if (r_done_early !== 1'b0 || r_done !== 1'b1) begin n_fail++; $display("FAIL sw_done_timing early=%0b at_ack+1=%0b want 0/1", r_done_early, r_done); end
    n_checks++; if (r_req_done !== 1'b0 || r_mis !== 1'b0 || r_ld !== 32'h0) begin n_fail++; $display("FAIL sw_resp req=%0b mis=%0b ld=%h want 0/0/0", r_req_done, r_mis, r_ld); end
    n_checks++; if (r_done_after !== 1'b0 || r_busy_after !== 1'b0) begin n_fail++; $display("FAIL sw_after done=%0b busy=%0b want 0/0", r_done_after, r_busy_after); end
  endtask

  task automatic test_store_lanes();
    logic [5:0]  c  [5] = '{ALU_SB, ALU_SB, ALU_SH, ALU_SH, ALU_SB};
    logic [31:0] a  [5] = '{32'h103, 32'h100, 32'h102, 32'h100, 32'h101};
    logic [31:0] d  [5] = '{32'h0000_00A5, 32'h1234_5678, 32'h0000_1234, 32'hABCD_5678, 32'h0000_00C3};
    logic [3:0]  es [5] = '{4'b1000, 4'b0001, 4'b1100, 4'b0011, 4'b0010};
    logic [31:0] ed [5] = '{32'hA5A5_A5A5, 32'h7878_7878, 32'h1234_1234, 32'h5678_5678, 32'hC3C3_C3C3};
    for (int i = 0; i < 5; i++) begin
      run_access(1'b0, 1'b1, c[i], a[i], d[i], 32'h0, i % 2);
      n_checks++; if (r_req !== 1'b1 || r_we !== 1'b1 || r_addr !== 32'h100) begin n_fail++; $display("FAIL st%0d_req req=%0b we=%0b addr=%h want 1/1/00000100", i, r_req, r_we, r_addr); end
      n_checks++; if (r_wstrb !== es[i]) begin n_fail++; $display("FAIL st%0d_wstrb got %b want %b", i, r_wstrb, es[i]); end
      n_checks++; if (r_wdata !== ed[i]) begin n_fail++; $display("FAIL st%0d_wdata got %h want %h", i, r_wdata, ed[i]); end
      n_checks++; if (r_held !== 1'b1 || r_done !== 1'b1 || r_mis !== 1'b0) begin n_fail++; $display("FAIL st%0d_resp held=%0b done=%0b mis=%0b want 1/1/0", i, r_held, r_done, r_mis); end
    end
  endtask

  task automatic test_loads();
    logic [5:0]  c  [8] = '{ALU_LB, ALU_LBU, ALU_LH, ALU_LHU, ALU_LW, ALU_LB, ALU_LH, ALU_LW};
    logic [31:0] a  [8] = '{32'h201, 32'h201, 32'h202, 32'h202, 32'h300, 32'h203, 32'h200, 32'h304};
    logic [31:0] rd [8] = '{32'h0000_800F, 32'h0000_800F, 32'hF00D_0000, 32'hF00D_0000,
                            32'h1234_5678, 32'h7F00_0000, 32'h0000_8001, 32'hCAFE_F00D};
    logic [31:0] el [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_F00D, 32'h0000_F00D,
                            32'h1234_5678, 32'h0000_007F, 32'hFFFF_8001, 32'hCAFE_F00D};
    logic [31:0] ea;
    for (int i = 0; i < 8; i++) begin
      ea = {a[i][31:2], 2'b00};
      run_access(1'b1, 1'b0, c[i], a[i], 32'hFFFF_FFFF, rd[i], (i == 7) ? 3 : i % 3);
      n_checks++; if (r_req !== 1'b1 || r_addr !== ea) begin n_fail++; $display("FAIL ld%0d_req req=%0b addr=%h want 1/%h", i, r_req, r_addr, ea); end
      n_checks++; if (r_we !== 1'b0 || r_wstrb !== 4'b0000) begin n_fail++; $display("FAIL ld%0d_we we=%0b wstrb=%b want 0/0000", i, r_we, r_wstrb); end
      n_checks++; if (r_done !== 1'b1 || r_mis !== 1'b0) begin n_fail++; $display("FAIL ld%0d_done done=%0b mis=%0b want 1/0", i, r_done, r_mis); end
      n_checks++; if (r_ld !== el[i]) begin n_fail++; $display("FAIL ld%0d_data got %h want %h", i, r_ld, el[i]); end
    end
  endtask

  task automatic test_misaligned();
    logic [5:0]  c  [4] = '{ALU_LW, ALU_SH, ALU_LHU, ALU_LH};
    logic [31:0] a  [4] = '{32'h302, 32'h101, 32'h205, 32'h200};
    logic        ld [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic        st [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_access(ld[i], st[i], c[i], a[i], 32'h1234_5678, 32'h0, 0);
      n_checks++; if (r_req !== 1'b0 || r_we !== 1'b0) begin n_fail++; $display("FAIL err%0d_req req=%0b we=%0b want 0/0", i, r_req, r_we); end
      n_checks++; if (r_done !== 1'b1 || r_mis !== 1'b1 || r_ld !== 32'h0) begin n_fail++; $display("FAIL err%0d_resp done=%0b mis=%0b ld=%h want 1/1/0", i, r_done, r_mis, r_ld); end
      n_checks++; if (r_done_after !== 1'b0 || r_mis_after !== 1'b0 || r_busy_after !== 1'b0) begin n_fail++; $display("FAIL err%0d_pulse done=%0b mis=%0b busy=%0b want 0/0/0", i, r_done_after, r_mis_after, r_busy_after); end
    end
    run_access(1'b1, 1'b0, ALU_LW, 32'h304, 32'h0, 32'h0BAD_CAFE, 0);
    n_checks++; if (r_req !== 1'b1 || r_done !== 1'b1 || r_mis !== 1'b0 || r_ld !== 32'h0BAD_CAFE) begin n_fail++; $display("FAIL err_recover req=%0b done=%0b mis=%0b ld=%h want 1/1/0/0badcafe", r_req, r_done, r_mis, r_ld); end
    // start without a load/store flag, and a stray ack while idle
    start = 1'b1; alucode = ALU_LW; addr = 32'h10; dmem_ack = 1'b1;
    tick();
    start = 1'b0; dmem_ack = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0 || done !== 1'b0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL idle_ignore busy=%0b done=%0b req=%0b want 0/0/0", busy, done, dmem_req); end
  endtask

  task automatic test_reset_abort();
    start = 1'b1; is_load = 1'b1; alucode = ALU_LW; addr = 32'h400;
    tick();
    start = 1'b0; is_load = 1'b0;
    n_checks++; if (dmem_req !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL abort_pre req=%0b busy=%0b want 1/1", dmem_req, busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (dmem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL abort_rst req=%0b busy=%0b done=%0b want 0/0/0", dmem_req, busy, done); end
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    tick();
    dmem_ack = 1'b0;
    tick();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0 || load_data !== 32'h0) begin n_fail++; $display("FAIL abort_late_ack done=%0b busy=%0b ld=%h want 0/0/0", done, busy, load_data); end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    start = 1'b1; is_load = 1'b1; alucode = ALU_LW; addr = 32'h500;
    tick();
    start = 1'b0; is_load = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_checks++; if (k !== TMO + 1) begin n_fail++; $display("FAIL tmo_cycles got %0d want %0d", k, TMO + 1); end
    n_checks++; if (misaligned !== 1'b1 || load_data !== 32'h0 || dmem_req !== 1'b0) begin n_fail++; $display("FAIL tmo_resp mis=%0b ld=%h req=%0b want 1/0/0", misaligned, load_data, dmem_req); end
    tick();
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL tmo_after done=%0b busy=%0b want 0/0", done, busy); end
    run_access(1'b1, 1'b0, ALU_LW, 32'h504, 32'h0, 32'hCAFE_F00D, TMO - 1);
    n_checks++; if (r_done !== 1'b1 || r_mis !== 1'b0 || r_ld !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL tmo_ack_wins done=%0b mis=%0b ld=%h want 1/0/cafef00d", r_done, r_mis, r_ld); end
  endtask
`endif

  initial begin
    test_reset();
    test_store_word();
    test_store_lanes();
    test_loads();
    test_misaligned();
    test_reset_abort();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage directly downstream of the execution stage.
- Consumes the ALU result as the effective address and rs2 as store data.
- Runs a request/acknowledge transaction on the data-memory port: byte-lane steering and write strobes for stores, lane extraction and sign/zero extension for loads.
- Stalls the pipeline via `busy` until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for dmem_ack (used only with MEM_TIMEOUT_EN).
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  access request from execution stage, one-cycle qualifier
- is_load  in  1  access is a load
- is_store  in  1  access is a store
- alucode  in  6  load/store kind: `ALU_LB/LH/LW/LBU/LHU/SB/SH/SW from define.vh
- addr  in  32  effective address (execution result)
- store_data  in  32  rs2 value
- busy  out  1  high while a transaction is outstanding; pipeline holds
- done  out  1  one-cycle pulse at completion
- load_data  out  32  extended load result, valid while done=1
- misaligned  out  1  one-cycle pulse with done on an alignment/illegal error
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable
- dmem_addr  out  32  word address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte write strobes
- dmem_ack  in  1  memory acknowledge; rdata valid same cycle
- dmem_rdata  in  32  read word

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - state=IDLE.
  - busy, done, misaligned, dmem_req, dmem_we = 0.
  - load_data, dmem_addr, dmem_wdata = 0; dmem_wstrb = 4'b0000; timeout counter = 0.
  - Reset mid-transaction aborts it: no done pulse; dmem_req low from the reset edge.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - start=1 with exactly one of is_load/is_store set and legal alignment → latch addr/alucode/lane data; next state ACCESS; busy=1 and dmem_req=1 registered at the next edge.
  - Error case → state RESP with misaligned=1 and no memory request. Errors are:
    - LH/LHU/SH with addr[0]=1
    - LW/SW with addr[1:0]≠0
    - is_load=is_store=1
  - start=1 with is_load=is_store=0 → ignored.
  - dmem_ack in IDLE is ignored.
- ACCESS:
  - dmem_req, dmem_addr, dmem_we, dmem_wdata, dmem_wstrb are held stable until dmem_ack=1.
  - On dmem_ack → RESP, capture the extended load result, drop dmem_req at that edge.
  - start is ignored while busy=1.
- RESP (one cycle):
  - done=1; busy drops to 0 at the next edge; return to IDLE.
  - load_data valid only for loads; 0 for stores and errors.
- Latency: start at cycle N, dmem_req high from N+1, ack at cycle M≥N+1, done at M+1. Minimum 3 cycles start-to-done. Error case: done+misaligned at N+1.
- Store steering (lane = addr[1:0]):
  - SB: wstrb = 4'b0001<<lane; wdata = {4{store_data[7:0]}}.
  - SH: wstrb = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{store_data[15:0]}}.
  - SW: wstrb = 4'b1111; wdata = store_data.
  - Loads: we=0, wstrb=0.
- Load extraction:
  - Byte = rdata[8*lane+:8]; LB sign-extends, LBU zero-extends.
  - Half = rdata[16*addr[1]+:16]; LH sign-extends, LHU zero-extends.
  - LW passes rdata.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - Counter increments each ACCESS cycle without ack.
  - On reaching TIMEOUT_CYCLES without ack: drop dmem_req, go RESP, done=1, misaligned=1, load_data=0.
  - If ack arrives in the expiry cycle, ack wins (normal completion).
  - Counter clears on entering ACCESS.
- Undefined: no counter; ACCESS waits indefinitely for ack.

Test Plan:
- SW addr=0x100, store_data=0xDEADBEEF, ack 2 cycles after req → dmem_addr=0x100, wstrb=1111, wdata=0xDEADBEEF, we=1, done exactly one cycle after ack, busy high throughout.
- SB addr=0x103, store_data=0x000000A5 → wstrb=1000, wdata=0xA5A5A5A5; SH addr=0x102, data=0x1234 → wstrb=1100, wdata=0x12341234.
- LB addr=0x201 with rdata=0x0000800F... (lane1=0x80) → load_data=0xFFFFFF80; LBU same → 0x00000080; LH addr=0x202, rdata=0xF00D0000 → 0xFFFFF00D; LHU → 0x0000F00D.
- LW addr=0x302 → no dmem_req, done=1 and misaligned=1 at N+1, load_data=0; then immediate legal LW accepted.
- rst asserted one cycle into ACCESS → dmem_req=0, busy=0, no done; late ack afterwards ignored.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, never ack → done+misaligned after 4 ACCESS cycles. Ack exactly on the 4th cycle → normal done, misaligned=0.
